// File: rtl/ext_int_pkg.sv
// Shared constants and register decode for the external interrupt controller.
package ext_int_pkg;

   localparam int ID_W_DEF = 5;

   localparam logic [3:0] REG_PENDING   = 4'h0;
   localparam logic [3:0] REG_ENABLE    = 4'h4;
   localparam logic [3:0] REG_EDGE_MODE = 4'h8;
   localparam logic [3:0] REG_CLAIM     = 4'hC;

   localparam logic [ID_W_DEF-1:0] CLAIM_NONE = '0;

   typedef enum logic [1:0] {
      SEL_PENDING,
      SEL_ENABLE,
      SEL_EDGE_MODE,
      SEL_CLAIM
   } reg_sel_e;

   // Caller guarantees the address is word aligned.
   function automatic reg_sel_e decode_sel(input logic [3:0] addr);
      reg_sel_e sel;
      case (addr)
         REG_ENABLE:    sel = SEL_ENABLE;
         REG_EDGE_MODE: sel = SEL_EDGE_MODE;
         REG_CLAIM:     sel = SEL_CLAIM;
         default:       sel = SEL_PENDING;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ext_int_controller_if.sv
// Register bus between software-facing master and the interrupt controller.
interface ext_int_controller_if;

   // Handshake: bus_req is a one-cycle request pulse; exactly one of bus_ack or
   // bus_err answers it in the following cycle; bus_rdata is valid only with
   // bus_ack on a read and is 0 otherwise. There is no back-pressure.
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_err, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_err, bus_rdata
   );

endinterface

// File: rtl/ext_int_gateway.sv
// Per-source gateway: synchronizer, trigger detection and pending/in-service state.
module ext_int_gateway (
   input  logic clk,
   input  logic reset,
   input  logic src_irq,
   input  logic edge_mode,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_service
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;
   logic pending_q, pending_d;
   logic in_service_q, in_service_d;
   logic trig;

   always_comb begin
      sync1_d      = src_irq;
      sync2_d      = sync1_q;
      prev_d       = sync2_q;
      // Rising-edge pulse is registered, so edge sources pend one edge after level ones.
      rise_d       = sync2_q & ~prev_q;
      trig         = edge_mode ? rise_q : sync2_q;
      pending_d    = pending_q;
      in_service_d = in_service_q;
      if (claim) begin
         pending_d    = 1'b0;
         in_service_d = 1'b1;
      end else begin
         if (trig && !pending_q && !in_service_q) pending_d = 1'b1;
         if (complete) in_service_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         rise_q       <= 1'b0;
         pending_q    <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         rise_q       <= rise_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   assign pending    = pending_q;
   assign in_service = in_service_q;

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller: per-source gateways, enable/edge registers,
// lowest-index claim priority and a registered single-cycle bus response.
module ext_int_controller
   import ext_int_pkg::*;
#(
   parameter int NUM_SOURCES = 8,
   parameter int ID_W        = ID_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] src_irq,
   ext_int_controller_if.slave    bus,
   output logic                   ext_int
);

   logic [NUM_SOURCES-1:0] enable_q, enable_d;
   logic [NUM_SOURCES-1:0] edge_mode_q, edge_mode_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   ext_int_q, ext_int_d;

   logic [NUM_SOURCES-1:0] pending;
   logic [NUM_SOURCES-1:0] in_service;
   logic [NUM_SOURCES-1:0] win_vec;
   logic [NUM_SOURCES-1:0] claim_vec;
   logic [NUM_SOURCES-1:0] complete_vec;
   logic [ID_W-1:0]        claim_id;
   logic                   aligned, rd_en, wr_en;
   reg_sel_e               sel;
   logic                   unused_wdata;

   assign unused_wdata = ^bus.bus_wdata[31:NUM_SOURCES];

   for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
      ext_int_gateway u_gateway (
         .clk        (clk),
         .reset      (reset),
         .src_irq    (src_irq[i]),
         .edge_mode  (edge_mode_q[i]),
         .claim      (claim_vec[i]),
         .complete   (complete_vec[i]),
         .pending    (pending[i]),
         .in_service (in_service[i])
      );
   end

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      claim_id = ID_W'(CLAIM_NONE);
      win_vec  = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (pending[i] && enable_q[i]) begin
            claim_id   = ID_W'(i + 1);
            win_vec    = '0;
            win_vec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      aligned     = (bus.bus_addr[1:0] == 2'b00);
      sel         = decode_sel(bus.bus_addr);
      rd_en       = bus.bus_req && aligned && !bus.bus_we;
      wr_en       = bus.bus_req && aligned && bus.bus_we;
      claim_vec   = (rd_en && sel == SEL_CLAIM) ? win_vec : '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         complete_vec[i] = wr_en && (sel == SEL_CLAIM) &&
                           (bus.bus_wdata[ID_W-1:0] == ID_W'(i + 1));
      end

      enable_d    = enable_q;
      edge_mode_d = edge_mode_q;
      if (wr_en && sel == SEL_ENABLE)    enable_d    = bus.bus_wdata[NUM_SOURCES-1:0];
      if (wr_en && sel == SEL_EDGE_MODE) edge_mode_d = bus.bus_wdata[NUM_SOURCES-1:0];

      rdata_d = '0;
      if (rd_en) begin
         case (sel)
            SEL_PENDING:   rdata_d = 32'(pending);
            SEL_ENABLE:    rdata_d = 32'(enable_q);
            SEL_EDGE_MODE: rdata_d = 32'(edge_mode_q);
            default:       rdata_d = 32'(claim_id);
         endcase
      end
      ack_d     = bus.bus_req && aligned;
      err_d     = bus.bus_req && !aligned;
      ext_int_d = |(pending & enable_q & ~in_service);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q    <= '0;
         edge_mode_q <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         ext_int_q   <= 1'b0;
      end else begin
         enable_q    <= enable_d;
         edge_mode_q <= edge_mode_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         ext_int_q   <= ext_int_d;
      end
   end

   assign bus.bus_ack   = ack_q;
   assign bus.bus_err   = err_q;
   assign bus.bus_rdata = rdata_q;
   assign ext_int       = ext_int_q;

endmodule

// File: doc/ext_int_controller.md
Name: ext_int_controller

Overview:
- Memory-mapped external interrupt controller upstream of the core.
- Aggregates NUM_SOURCES asynchronous device interrupt lines and performs per-source gating: level or rising-edge, enable, claim/complete.
- Drives the core's single ext_int input.
- Software reads the claim register to identify and acknowledge the winning source, and writes it back to complete.

Parameters:
- NUM_SOURCES, 8, number of interrupt source lines (1..31).
- ID_W, 5, width of a source ID field; ID 0 means "none", source i has ID i+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- src_irq  in  NUM_SOURCES  raw device interrupt lines, asynchronous to clk
- bus_req  in  1  register access request, single-cycle pulse
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  4  byte offset within the controller
- bus_wdata  in  32  write data
- bus_ack  out  1  access completed, 1 cycle after bus_req
- bus_err  out  1  access faulted, 1 cycle after bus_req, exclusive with bus_ack
- bus_rdata  out  32  read data, valid with bus_ack, 0 otherwise
- ext_int  out  1  registered interrupt request to the core

Behaviour:
- Reset values: pending, enable, edge_mode and in_service all 0; synchronizer flops and previous-level flops 0; bus_ack, bus_err, bus_rdata and ext_int all 0.
- Reset mid-access drops the access; no ack or err is produced.
- Synchronizer: 2-flop per source. sync[i] reflects src_irq[i] after 2 clk edges.
- Trigger per source:
  - Level mode (edge_mode[i]=0): trig = sync[i].
  - Edge mode: trig = sync[i] & ~prev[i], where prev[i] is sync[i] delayed one cycle.
- Pending set: when trig & ~pending[i] & ~in_service[i].
  - A trigger while pending or in_service is dropped; an edge during service is lost.
  - A level source re-pends the cycle after completion if still high.
- Register map, word-aligned:
  - 0x0 PENDING: read-only; writes are ignored and acked.
  - 0x4 ENABLE: read/write, bits [NUM_SOURCES-1:0].
  - 0x8 EDGE_MODE: read/write, bits [NUM_SOURCES-1:0].
  - 0xC CLAIM/COMPLETE:
    - Read returns the ID of the lowest-index source with pending & enable set, zero-extended; 0 if none.
    - The same read atomically clears pending and sets in_service for that source.
    - A write with bus_wdata[ID_W-1:0] = k in 1..NUM_SOURCES clears in_service[k-1]; other values are ignored and acked.
  - Unused bits read 0; writes to unused bits are ignored.
- Faults: bus_addr[1:0] != 0 gives bus_err. Register state is unchanged and no claim side effect occurs.
- Bus timing: the response is registered. bus_req at edge N gives bus_ack or bus_err high for exactly the cycle after edge N+1. Back-to-back requests are legal.
- ext_int: registered |(pending & enable & ~in_service). It goes high the cycle after the qualifying pending bit sets.
- End-to-end latency, src_irq rising before edge 0:
  - sync at edge 1;
  - pending at edge 2 (level) or edge 3 (edge mode, including prev);
  - ext_int one edge later.
- Simultaneous events:
  - A claim read in the same cycle as a new trigger on the claimed source: the claim wins and the trigger is dropped.
  - A new trigger on another source the same cycle is captured normally.
  - ENABLE written 0 while pending: the pending bit is retained and ext_int deasserts next cycle.
  - Complete for a source not in service: no effect.

Decomposition:
- Package ext_int_pkg holds:
  - register offset constants (PENDING, ENABLE, EDGE_MODE, CLAIM);
  - the ID_W default;
  - the claim-ID "none" constant.
- Sub-module ext_int_gateway, one instance per source, holds synchronizer, prev flop, pending and in_service bits.
  - Inputs: edge_mode, claim, complete.
  - Outputs: pending, in_service.
- The top level holds ENABLE/EDGE_MODE registers, the lowest-index priority encoder, bus decode/response and the ext_int register.

Test Plan:
- Level source 3, ENABLE=0x08, hold src_irq[3]=1 -> ext_int=1 by 4th edge; read 0xC -> rdata=4, ext_int=0 next cycle; write 4 to 0xC -> source re-pends, ext_int=1 again within 2 cycles.
- Sources 5 and 2 pending, ENABLE=0xFF -> read 0xC returns 3, then 6, then 0; PENDING reads 0x24, 0x20, 0x00 between claims.
- EDGE_MODE=0x01, pulse src_irq[0] for 3 cycles -> PENDING=0x01; claim returns 1; pulse again before complete -> PENDING stays 0x00 (edge lost); complete then pulse -> PENDING=0x01.
- Read address 0x6 -> bus_err=1, bus_ack=0, rdata=0, no pending or in_service change; write 0x5A to 0x0 -> ack, PENDING unchanged.
- Source 1 pending with ENABLE=0 -> ext_int=0 and claim returns 0 with PENDING still 0x02; write ENABLE=0x02 -> ext_int=1 next cycle.
- Assert reset while source 4 is in_service and a read is in flight -> no ack, all registers 0, ext_int=0 the cycle after reset.
